elut_multi_cfg: RTL and testbench
=================================

// Module: elut_multi_cfg
//
// PURPOSE
//  Parametrised multi-channel LUTRAM element: NUM_LUTS independent K-input LUTs.
//  Each LUT has a combinational output and an optional registered output.
//  Truth tables are reloaded at run time by a serial bit-stream loader FSM with a
//  valid/ready handshake; INIT_MASK is the power-on and reset contents.
//  Sits in the overlay logic cluster in place of single fixed-mask LUT/DFF pairs.
//
// PARAMETERS
//  K          6                           inputs per LUT; 2**K table bits per LUT
//  NUM_LUTS   2                           number of LUT channels (>=1)
//  REG_OUT    1                           1: qdpo is registered; 0: qdpo = dpo
//  INIT_MASK  {NUM_LUTS*2**K{1'b0}}       [0:NUM_LUTS*2**K-1]; LUT i bit j at index i*2**K+j
//
// PORTS
//  clk        in   1             single clock; all state on rising edge
//  rst_n      in   1             asynchronous, active-low reset
//  cfg_start  in   1             begin (or restart) table reload
//  cfg_valid  in   1             cfg_data beat valid
//  cfg_data   in   1             serial table bit
//  cfg_ready  out  1             loader accepts a beat this cycle
//  cfg_done   out  1             one-cycle pulse after the last beat is written
//  dpra       in   NUM_LUTS*K    read address; LUT i uses dpra[i*K +: K]
//  qdpo_en    in   1             clock enable for the registered outputs
//  dpo        out  NUM_LUTS      combinational LUT outputs
//  qdpo       out  NUM_LUTS      registered LUT outputs
//
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - table <= INIT_MASK; FSM=IDLE; bit/LUT counters=0.
//    - cfg_ready=0, cfg_done=0, qdpo=0.
//    - Reset during LOAD discards any partially loaded contents; the table reverts to INIT_MASK.
//  - Read: dpo[i] = table[i][dpra[i*K +: K]], purely combinational, no latency.
//    A table write is visible on dpo in the cycle after the accepting edge.
//  - qdpo (REG_OUT=1): qdpo[i] <= dpo[i] on clk when qdpo_en=1; otherwise holds.
//    Latency is 1 cycle. Registers keep updating during LOAD.
//  - qdpo (REG_OUT=0): qdpo = dpo; qdpo_en is ignored.
//  - FSM states IDLE, LOAD, DONE:
//    - IDLE: cfg_ready=0.
//      - cfg_start=1 -> LOAD, with bit_cnt=0 and lut_cnt=0.
//    - LOAD: cfg_ready=1.
//      - Beat accepted when cfg_valid & cfg_ready: table[lut_cnt][bit_cnt] <= cfg_data.
//      - bit_cnt increments and wraps at 2**K-1 to 0; lut_cnt increments on that wrap.
//      - Accepting beat number NUM_LUTS*2**K-1 (the last) -> DONE.
//      - cfg_valid=0 stalls the load indefinitely; counters hold.
//      - cfg_start=1 restarts the load: counters go to 0 and any same-cycle beat is dropped
//        (restart wins). Already written bits stay until they are overwritten.
//    - DONE: cfg_done=1 for exactly one cycle, cfg_ready=0 -> IDLE.
//      A cfg_start in DONE is ignored.
//  - Stream order: LUT 0 bit 0 first, then LUT 0 bit 2**K-1, then LUT 1 bit 0, and so on.
//  - Beats presented while cfg_ready=0 are ignored and write nothing.
//  - Counter widths: bit_cnt is K bits; lut_cnt is max(1,$clog2(NUM_LUTS)) bits.
//    Neither counter exceeds its terminal value.
//
// TESTING
//  - Reset, default INIT_MASK, K=6, NUM_LUTS=2:
//    sweep dpra over all 4096 combinations -> dpo=0 and qdpo=0 throughout.
//  - INIT_MASK with LUT0 bit 5 and LUT1 bit 63 set:
//    - dpra={6'd63,6'd5} -> dpo=2'b11.
//    - With qdpo_en=1, qdpo=2'b11 one edge later.
//    - With qdpo_en=0, qdpo holds its previous value.
//  - Full reload with the alternating stream 1,0,1,0 (128 beats, valid every cycle):
//    - cfg_ready is high for exactly 128 cycles.
//    - cfg_done pulses once, on the cycle after beat 127.
//    - Afterwards dpo[i]=~dpra[i*K] for all addresses.
//  - Reload with cfg_valid toggling randomly at 50% duty:
//    the final table matches the stream; cfg_done rises only after the 128th accepted beat.
//  - cfg_start reasserted at beat 40 together with cfg_valid=1:
//    that beat is dropped, counters restart, and the next beat writes LUT0 bit 0.
//  - rst_n low at beat 70 of a reload:
//    - Immediately: cfg_ready=0 and qdpo=0.
//    - After release: table=INIT_MASK and the FSM is in IDLE.
//  - REG_OUT=0 build: qdpo tracks dpo combinationally and is unaffected by qdpo_en.

Source files
------------

// File: rtl/elut_multi_cfg.sv
// elut_multi_cfg: NUM_LUTS independent K-input LUTRAM channels with a serial
// bit-stream reload engine.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_start             begin / restart a table reload
//   cfg_valid, cfg_data   serial table beat (one bit per accepted beat)
//   cfg_ready             loader accepts a beat this cycle (registered)
//   cfg_done              one-cycle pulse after the last beat is written (registered)
//   dpra                  read address, LUT i uses dpra[i*K +: K]
//   qdpo_en               clock enable for the registered outputs
//   dpo                   combinational LUT outputs
//   qdpo                  registered (REG_OUT=1) or pass-through (REG_OUT=0) outputs
module elut_multi_cfg #(
    parameter int unsigned K        = 6,
    parameter int unsigned NUM_LUTS = 2,
    parameter int unsigned REG_OUT  = 1,
    parameter logic [0:NUM_LUTS*(2**K)-1] INIT_MASK = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_valid,
    input  logic                  cfg_data,
    output logic                  cfg_ready,
    output logic                  cfg_done,
    input  logic [NUM_LUTS*K-1:0] dpra,
    input  logic                  qdpo_en,
    output logic [NUM_LUTS-1:0]   dpo,
    output logic [NUM_LUTS-1:0]   qdpo
);

    localparam int unsigned DEPTH = 2**K;
    localparam int unsigned LW    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                         state;
    logic [K-1:0]                   bit_cnt;
    logic [LW-1:0]                  lut_cnt;
    logic [NUM_LUTS-1:0][DEPTH-1:0] tbl;
    logic                           accept;
    logic                           bit_last;
    logic                           last_beat;

    // A restart in the same cycle as a beat drops the beat.
    assign accept    = (state == LOAD) && cfg_valid && !cfg_start;
    assign bit_last  = (bit_cnt == K'(DEPTH - 1));
    assign last_beat = bit_last && (lut_cnt == LW'(NUM_LUTS - 1));

    // Loader FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            lut_cnt   <= '0;
            cfg_ready <= 1'b0;
            cfg_done  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state     <= LOAD;
                        bit_cnt   <= '0;
                        lut_cnt   <= '0;
                        cfg_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        bit_cnt <= '0;
                        lut_cnt <= '0;
                    end else if (cfg_valid) begin
                        if (last_beat) begin
                            // Counters park at their terminal values until the next start.
                            state     <= DONE;
                            cfg_ready <= 1'b0;
                            cfg_done  <= 1'b1;
                        end else if (bit_last) begin
                            bit_cnt <= '0;
                            lut_cnt <= lut_cnt + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    // Truth-table storage; reset restores the power-on mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_LUTS; i++) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    tbl[i][j] <= INIT_MASK[i*DEPTH + j];
                end
            end
        end else if (accept) begin
            tbl[lut_cnt][bit_cnt] <= cfg_data;
        end
    end

    // Combinational table read per channel.
    always_comb begin
        dpo = '0;
        for (int unsigned i = 0; i < NUM_LUTS; i++) begin
            dpo[i] = tbl[i][dpra[i*K +: K]];
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            // Output register keeps sampling during a reload.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    qdpo <= '0;
                end else if (qdpo_en) begin
                    qdpo <= dpo;
                end
            end
        end else begin : g_comb
            logic unused_qdpo_en;
            assign unused_qdpo_en = qdpo_en;
            assign qdpo           = dpo;
        end
    endgenerate

endmodule

// File: tb/tb_elut_multi_cfg.sv
// Scoreboard bench for elut_multi_cfg: three instances share one stimulus
// stream (default mask / registered, two-bit mask / registered, two-bit mask /
// pass-through). The driver pushes per-cycle expectations from a flat-array
// reference model; a negedge monitor pops and compares.
module tb_elut_multi_cfg;

    localparam int unsigned TOT = 128;
    // Ascending [0:127]: index 5 (LUT0 bit 5) and index 127 (LUT1 bit 63).
    localparam logic [0:TOT-1] MASK_M = 128'h0400_0000_0000_0000_0000_0000_0000_0001;

    typedef struct packed {
        logic [5:0] dpo;
        logic [5:0] qdpo;
        logic       ready;
        logic       done;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_data = 1'b0;
    logic        qdpo_en = 1'b0;
    logic [11:0] dpra = '0;

    logic        rdy_d, rdy_m, rdy_z, dn_d, dn_m, dn_z;
    logic [1:0]  dpo_d, dpo_m, dpo_z, q_d, q_m, q_z;

    int checks = 0;
    int failures = 0;
    int ready_seen = 0;
    int done_seen = 0;

    exp_t        expq[$];

    // Reference model: flat tables indexed lut*64+bit, beat counter in stream order.
    logic [TOT-1:0] mt [3];
    logic [1:0]     mq [3];
    logic           m_load, m_done;
    int             m_n;

    always #5 clk = ~clk;

    elut_multi_cfg #(.K(6), .NUM_LUTS(2), .REG_OUT(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_ready(rdy_d), .cfg_done(dn_d), .dpra(dpra),
        .qdpo_en(qdpo_en), .dpo(dpo_d), .qdpo(q_d));

    elut_multi_cfg #(.K(6), .NUM_LUTS(2), .REG_OUT(1), .INIT_MASK(MASK_M)) dut_m (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_ready(rdy_m), .cfg_done(dn_m), .dpra(dpra),
        .qdpo_en(qdpo_en), .dpo(dpo_m), .qdpo(q_m));

    elut_multi_cfg #(.K(6), .NUM_LUTS(2), .REG_OUT(0), .INIT_MASK(MASK_M)) dut_z (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_ready(rdy_z), .cfg_done(dn_z), .dpra(dpra),
        .qdpo_en(qdpo_en), .dpo(dpo_z), .qdpo(q_z));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    function automatic logic [1:0] mdpo(input int d, input logic [11:0] a);
        logic [1:0] r;
        for (int i = 0; i < 2; i++) r[i] = mt[d][i*64 + int'(a[i*6 +: 6])];
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < TOT; k++) mt[d][k] = (d == 0) ? 1'b0 : MASK_M[k];
            mq[d] = 2'b00;
        end
        m_load = 1'b0;
        m_done = 1'b0;
        m_n    = 0;
    endtask

    task automatic push_expect();
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            e.dpo[d*2 +: 2]  = mdpo(d, dpra);
            e.qdpo[d*2 +: 2] = (d < 2) ? mq[d] : mdpo(d, dpra);
        end
        e.ready = m_load;
        e.done  = m_done;
        expq.push_back(e);
    endtask

    // Effect of one rising edge with the currently applied inputs.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) if (qdpo_en) mq[d] = mdpo(d, dpra);
        if (m_load) begin
            if (cfg_start) m_n = 0;
            else if (cfg_valid) begin
                for (int d = 0; d < 3; d++) mt[d][m_n] = cfg_data;
                m_n++;
                if (m_n == TOT) begin
                    m_load = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (cfg_start) begin
            m_load = 1'b1;
            m_n    = 0;
        end
    endtask

    task automatic step(input logic st, input logic vl, input logic dt, input logic en,
                        input logic [11:0] a, input logic rn);
        cfg_start = st;
        cfg_valid = vl;
        cfg_data  = dt;
        qdpo_en   = en;
        dpra      = a;
        rst_n     = rn;
        if (!rn) model_reset();
        push_expect();
        if (rn) model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    // Monitor: compare every driven cycle against its queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("dpo",   32'({dpo_z, dpo_m, dpo_d}), 32'(e.dpo));
            chk("qdpo",  32'({q_z, q_m, q_d}),       32'(e.qdpo));
            chk("ready", 32'({rdy_z, rdy_m, rdy_d}), 32'({3{e.ready}}));
            chk("done",  32'({dn_z, dn_m, dn_d}),    32'({3{e.done}}));
            if (rdy_m) ready_seen++;
            if (dn_m)  done_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        model_reset();
        @(posedge clk);
        #1;
        // Reset and release.
        step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 12'hFFF, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1);

        // Full address sweep against reset contents.
        for (int a = 0; a < 4096; a++) step(1'b0, 1'b0, 1'b0, 1'b1, 12'(a), 1'b1);

        // Mask hit, registered capture, then hold with qdpo_en low.
        step(1'b0, 1'b0, 1'b0, 1'b1, {6'd63, 6'd5}, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1);

        // Beats while idle write nothing.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, r1(), r1(), 12'($urandom), 1'b1);

        // Alternating full reload, valid every cycle; start in DONE is ignored.
        ready_seen = 0;
        done_seen  = 0;
        step(1'b1, 1'b0, 1'b0, 1'b1, 12'($urandom), 1'b1);
        for (int b = 0; b < 128; b++) step(1'b0, 1'b1, (b % 2) == 0, r1(), 12'($urandom), 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 12'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 12'($urandom), 1'b1);
        chk("ready_cycles", 32'(ready_seen), 32'd128);
        chk("done_pulses",  32'(done_seen),  32'd1);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b0, 1'b0, r1(), 12'($urandom), 1'b1);

        // Reload with random 50% valid and random data.
        step(1'b1, 1'b0, 1'b0, 1'b1, 12'($urandom), 1'b1);
        guard = 0;
        while (m_load && guard < 1000) begin
            step(1'b0, r1(), r1(), r1(), 12'($urandom), 1'b1);
            guard++;
        end
        chk("rand_load_bound", 32'(m_load), 32'd0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 1'b0, r1(), 12'($urandom), 1'b1);

        // Restart at beat 40 with a same-cycle beat, then a full load.
        step(1'b1, 1'b0, 1'b0, 1'b1, 12'($urandom), 1'b1);
        for (int b = 0; b < 40; b++) step(1'b0, 1'b1, r1(), 1'b1, 12'($urandom), 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 12'($urandom), 1'b1);
        for (int b = 0; b < 128; b++) step(1'b0, 1'b1, r1(), 1'b1, 12'($urandom), 1'b1);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b0, 1'b0, r1(), 12'($urandom), 1'b1);

        // Reset in the middle of a reload (beat 70).
        step(1'b1, 1'b0, 1'b0, 1'b1, 12'($urandom), 1'b1);
        for (int b = 0; b < 70; b++) step(1'b0, 1'b1, r1(), 1'b1, 12'($urandom), 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 12'($urandom), 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 12'($urandom), 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, {6'd63, 6'd5}, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, r1(), r1(), 12'($urandom), 1'b1);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b0, 1'b0, r1(), 12'($urandom), 1'b1);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
